// File: rtl/conv2_deactivation.sv
// Layer-2 activation expander: unpacks LANES 8-bit codes per word and emits one
// approximate 14-bit linear value per cycle, with a sticky saturating illegal-code count.
module conv2_deactivation #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned MID_ROUND = 1,
  localparam int unsigned LW       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [13:0]        out_data,
  output logic [LW-1:0]      out_lane,
  output logic               out_err,
  input  logic               err_clr,
  output logic [15:0]        err_cnt
);

  localparam logic [14:0] OFF_MID = (MID_ROUND != 0) ? 15'd16 : 15'd0;
  localparam logic [14:0] OFF_HI  = (MID_ROUND != 0) ? 15'd64 : 15'd0;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  logic [8*LANES-1:0] buf_q, buf_d;
  logic               full_q, full_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic [15:0]        err_cnt_q, err_cnt_d;

  logic [7:0]  lane_codes [LANES];
  logic [7:0]  code;
  logic [14:0] code_w;
  logic [13:0] dec_val;
  logic        dec_err;
  logic        last_lane;
  logic        load;
  logic        handoff;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_codes[gi] = buf_q[8*gi +: 8];
  end

  assign code   = lane_codes[lane_q];
  assign code_w = {7'd0, code};

  // Piecewise expansion; each branch stays below 2^14 so truncation is lossless.
  always_comb begin
    dec_val = 14'd0;
    dec_err = 1'b0;
    if (code < 8'd64) begin
      dec_val = code_w[13:0];
    end else if (code < 8'd190) begin
      dec_val = 14'(((code_w - 15'd62) << 5) + OFF_MID);
    end else if (code < 8'd222) begin
      dec_val = 14'(((code_w - 15'd158) << 7) + OFF_HI);
    end else begin
      dec_val = 14'h3FFF;
      dec_err = 1'b1;
    end
  end

  assign last_lane = (lane_q == LAST_LANE);
  assign in_ready  = !full_q | (out_ready & last_lane);
  assign load      = in_valid & in_ready;
  assign handoff   = full_q & out_ready;

  // A load on the final-lane handoff edge keeps the buffer full with no bubble.
  always_comb begin
    buf_d     = buf_q;
    full_d    = full_q;
    lane_d    = lane_q;
    err_cnt_d = err_cnt_q;
    if (load) begin
      buf_d  = in_data;
      lane_d = '0;
      full_d = 1'b1;
    end else if (handoff) begin
      if (last_lane) full_d = 1'b0;
      else           lane_d = lane_q + 1'b1;
    end
    if (err_clr) begin
      err_cnt_d = 16'd0;
    end else if (handoff && dec_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q     <= '0;
      full_q    <= 1'b0;
      lane_q    <= '0;
      err_cnt_q <= 16'd0;
    end else begin
      buf_q     <= buf_d;
      full_q    <= full_d;
      lane_q    <= lane_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = dec_val;
  assign out_err   = dec_err;
  assign out_lane  = lane_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_conv2_deactivation.sv
// Directed bench for conv2_deactivation: one instance with mid-bucket rounding,
// one in floor mode, both fed the same input stream.
module tb_conv2_deactivation;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        err_clr;

  logic        r_in_ready, r_out_valid, r_out_err;
  logic [13:0] r_out_data;
  logic [1:0]  r_out_lane;
  logic [15:0] r_err_cnt;

  logic        f_in_ready, f_out_valid, f_out_err;
  logic [13:0] f_out_data;
  logic [1:0]  f_out_lane;
  logic [15:0] f_err_cnt;

  int checks;
  int failures;

  conv2_deactivation #(.LANES(4), .MID_ROUND(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .out_lane(r_out_lane), .out_err(r_out_err),
    .err_clr(err_clr), .err_cnt(r_err_cnt)
  );

  conv2_deactivation #(.LANES(4), .MID_ROUND(0)) dut_floor (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(f_in_ready), .in_data(in_data),
    .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_out_data),
    .out_lane(f_out_lane), .out_err(f_out_err),
    .err_clr(err_clr), .err_cnt(f_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (r_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", r_out_valid); end
    checks++; if (r_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", r_in_ready); end
    checks++; if (r_out_data !== 14'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", r_out_data); end
    checks++; if (r_out_lane !== 2'd0 || r_out_err !== 1'b0) begin failures++; $display("FAIL reset_lane_err got=%0d/%b exp=0/0", r_out_lane, r_out_err); end
    checks++; if (r_err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", r_err_cnt); end
    rst = 1'b0;
    $display("reset: out_valid=%b in_ready=%b err_cnt=%0d", r_out_valid, r_in_ready, r_err_cnt);
  endtask

  task automatic test_decode();
    int er [4] = '{4160, 4080, 80, 63};
    int ef [4] = '{4096, 4064, 64, 63};
    in_valid = 1'b1; in_data = 32'h3F40BDBE; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (r_out_valid !== 1'b1 || r_out_lane !== 2'(i)) begin failures++; $display("FAIL decode_lane%0d valid/lane got=%b/%0d exp=1/%0d", i, r_out_valid, r_out_lane, i); end
      checks++; if (r_out_data !== 14'(er[i]) || r_out_err !== 1'b0) begin failures++; $display("FAIL decode_round_lane%0d got=%0d/%b exp=%0d/0", i, r_out_data, r_out_err, er[i]); end
      checks++; if (f_out_data !== 14'(ef[i])) begin failures++; $display("FAIL decode_floor_lane%0d got=%0d exp=%0d", i, f_out_data, ef[i]); end
      $display("decode lane=%0d round=%0d floor=%0d err=%b", r_out_lane, r_out_data, f_out_data, r_out_err);
      @(posedge clk); #1;
    end
    checks++; if (r_out_valid !== 1'b0) begin failures++; $display("FAIL decode_drained got=%b exp=0", r_out_valid); end
  endtask

  task automatic test_floor_extra();
    int er [4] = '{8128, 2, 0, 0};
    int ef [4] = '{8064, 2, 0, 0};
    in_valid = 1'b1; in_data = 32'h000002DD; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (f_out_data !== 14'(ef[i]) || r_out_data !== 14'(er[i])) begin failures++; $display("FAIL floor_extra_lane%0d got=%0d/%0d exp=%0d/%0d", i, f_out_data, r_out_data, ef[i], er[i]); end
      $display("floor lane=%0d floor=%0d round=%0d", f_out_lane, f_out_data, r_out_data);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    int er [4]   = '{16383, 8128, 16383, 16383};
    int ef [4]   = '{16383, 8064, 16383, 16383};
    bit ee [4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
    int ecnt [4] = '{0, 1, 1, 2};
    in_valid = 1'b1; in_data = 32'hFFDEDDDE; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (r_out_data !== 14'(er[i]) || r_out_err !== ee[i]) begin failures++; $display("FAIL illegal_lane%0d got=%0d/%b exp=%0d/%b", i, r_out_data, r_out_err, er[i], ee[i]); end
      checks++; if (f_out_data !== 14'(ef[i])) begin failures++; $display("FAIL illegal_floor_lane%0d got=%0d exp=%0d", i, f_out_data, ef[i]); end
      checks++; if (r_err_cnt !== 16'(ecnt[i])) begin failures++; $display("FAIL illegal_cnt_lane%0d got=%0d exp=%0d", i, r_err_cnt, ecnt[i]); end
      $display("illegal lane=%0d data=%0d err=%b err_cnt=%0d", r_out_lane, r_out_data, r_out_err, r_err_cnt);
      @(posedge clk); #1;
    end
    checks++; if (r_err_cnt !== 16'd3 || f_err_cnt !== 16'd3) begin failures++; $display("FAIL illegal_cnt_final got=%0d/%0d exp=3", r_err_cnt, f_err_cnt); end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (r_err_cnt !== 16'd5 || r_out_lane !== 2'd3) begin failures++; $display("FAIL illegal_cnt_before_clr got=%0d lane=%0d exp=5 lane=3", r_err_cnt, r_out_lane); end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++; if (r_err_cnt !== 16'd0) begin failures++; $display("FAIL illegal_clr_wins got=%0d exp=0", r_err_cnt); end
    $display("illegal clear-with-increment err_cnt=%0d", r_err_cnt);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    int wi = 0;
    bit fire;
    in_valid = 1'b1; in_data = w[0]; out_ready = 1'b1;
    #1;
    for (int n = 0; n < 12; n++) begin
      fire = in_valid && r_in_ready;
      @(posedge clk); #1;
      if (fire) begin
        wi++;
        if (wi < 3) in_data = w[wi];
        else        in_valid = 1'b0;
      end
      #1;
      checks++; if (r_out_valid !== 1'b1 || r_out_data !== 14'(n + 1)) begin failures++; $display("FAIL b2b_value%0d got=%b/%0d exp=1/%0d", n, r_out_valid, r_out_data, n + 1); end
      checks++; if (r_in_ready !== (n % 4 == 3)) begin failures++; $display("FAIL b2b_in_ready%0d got=%b exp=%b", n, r_in_ready, (n % 4 == 3)); end
      $display("b2b n=%0d lane=%0d data=%0d in_ready=%b", n, r_out_lane, r_out_data, r_in_ready);
    end
    @(posedge clk); #1;
    checks++; if (r_out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", r_out_valid); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_data = 32'h04030201; out_ready = 1'b1;
    @(posedge clk); #1;
    in_data = 32'h08070605;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (r_out_valid !== 1'b1 || r_out_lane !== 2'd2 || r_out_data !== 14'd3) begin failures++; $display("FAIL stall%0d got=%b/%0d/%0d exp=1/2/3", c, r_out_valid, r_out_lane, r_out_data); end
      checks++; if (r_in_ready !== 1'b0) begin failures++; $display("FAIL stall%0d_in_ready got=%b exp=0", c, r_in_ready); end
      $display("stall c=%0d lane=%0d data=%0d in_ready=%b", c, r_out_lane, r_out_data, r_in_ready);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    for (int n = 2; n < 8; n++) begin
      checks++; if (r_out_valid !== 1'b1 || r_out_data !== 14'(n + 1) || r_out_lane !== 2'(n % 4)) begin failures++; $display("FAIL resume%0d got=%b/%0d/%0d exp=1/%0d/%0d", n, r_out_valid, r_out_data, r_out_lane, n + 1, n % 4); end
      $display("resume lane=%0d data=%0d", r_out_lane, r_out_data);
      @(posedge clk); #1;
      if (n == 3) in_valid = 1'b0;
    end
    checks++; if (r_out_valid !== 1'b0) begin failures++; $display("FAIL resume_drained got=%b exp=0", r_out_valid); end
  endtask

  task automatic test_saturation();
    in_valid = 1'b1; in_data = 32'hFFFFFFFF; out_ready = 1'b1;
    @(posedge clk);
    repeat (65534) @(posedge clk);
    #1;
    checks++; if (r_err_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_count_65534 got=%h exp=fffe", r_err_cnt); end
    repeat (6) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (r_err_cnt !== 16'hFFFF || f_err_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_count_65540 got=%h/%h exp=ffff", r_err_cnt, f_err_cnt); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (r_err_cnt !== 16'hFFFF || r_out_valid !== 1'b0) begin failures++; $display("FAIL sat_hold got=%h/%b exp=ffff/0", r_err_cnt, r_out_valid); end
    $display("saturation err_cnt=%h", r_err_cnt);
  endtask

  task automatic test_reset_mid_word();
    in_valid = 1'b1; in_data = 32'hFF0302FF; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (r_out_lane !== 2'd2 || r_out_data !== 14'd3) begin failures++; $display("FAIL midrst_pre got=%0d/%0d exp=2/3", r_out_lane, r_out_data); end
    rst = 1'b1;
    #1;
    checks++; if (r_out_valid !== 1'b0 || r_in_ready !== 1'b1) begin failures++; $display("FAIL midrst_flags got=%b/%b exp=0/1", r_out_valid, r_in_ready); end
    checks++; if (r_err_cnt !== 16'd0 || r_out_lane !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d/%0d exp=0/0", r_err_cnt, r_out_lane); end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 32'h0D0C0B0A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (r_out_valid !== 1'b1 || r_out_lane !== 2'(i) || r_out_data !== 14'(10 + i)) begin failures++; $display("FAIL midrst_next_lane%0d got=%b/%0d/%0d exp=1/%0d/%0d", i, r_out_valid, r_out_lane, r_out_data, i, 10 + i); end
      $display("after reset lane=%0d data=%0d err_cnt=%0d", r_out_lane, r_out_data, r_err_cnt);
      @(posedge clk); #1;
    end
    checks++; if (r_err_cnt !== 16'd0 || r_out_valid !== 1'b0) begin failures++; $display("FAIL midrst_end got=%0d/%b exp=0/0", r_err_cnt, r_out_valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_decode();
    test_floor_extra();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
